serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl_pkg.sv | 12 +
 rtl/serial_adder_ctrl_fa.sv | 42 ++++
 rtl/serial_adder_ctrl.sv | 133 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: controller state encoding and default width.
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage : serial_adder_ctrl_pkg

// File: rtl/serial_adder_ctrl_fa.sv
// One-bit full-adder slice for the serial adder, composed of two half adders.
module half_adder_dataflow (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule : half_adder_dataflow

module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic ha0_s_s;
  logic ha0_c_s;
  logic ha1_c_s;

  half_adder_dataflow u_ha0 (
    .a (a),
    .b (b),
    .s (ha0_s_s),
    .c (ha0_c_s)
  );

  half_adder_dataflow u_ha1 (
    .a (ha0_s_s),
    .b (cin),
    .s (s),
    .c (ha1_c_s)
  );

  assign cout = ha0_c_s | ha1_c_s;

endmodule : serial_fa_cell

// File: rtl/serial_adder_ctrl.sv
// Bit-serial unsigned adder: one full-adder slice reused over WIDTH cycles, LSB first.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             CARRY
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cy_q, cy_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fa_s_s;
  logic             fa_cout_s;
  logic [WIDTH-1:0] res_shift_s;

  serial_fa_cell u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (cy_q),
    .s    (fa_s_s),
    .cout (fa_cout_s)
  );

  // Sum bits enter at the MSB so the result is LSB-aligned after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_shift_s = fa_s_s;
    end else begin : g_res_wn
      assign res_shift_s = {fa_s_s, res_q[WIDTH-1:1]};
    end
  endgenerate

  // Next-state and datapath update for the controller.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cy_d    = cy_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          a_d     = A;
          b_d     = B;
          res_d   = {WIDTH{1'b0}};
          cy_d    = 1'b0;
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_ADD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADD: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = res_shift_s;
        cy_d  = fa_cout_s;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          sum_d   = res_shift_s;
          carry_d = fa_cout_s;
          state_d = ST_FIN;
        end else begin
          state_d = ST_ADD;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_ADD);
    done_d = (state_d == ST_FIN);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      res_q   <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      cy_q    <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cy_q    <= cy_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign SUM   = sum_q;
  assign CARRY = carry_q;

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, start1;
  logic [7:0] a8, b8;
  logic [0:0] a1, b1;
  logic       busy8, done8, carry8;
  logic [7:0] sum8;
  logic       busy1, done1, carry1;
  logic [0:0] sum1;

  int total = 0;
  int bad   = 0;

  logic [7:0] mdl_sum   = 8'h00;
  logic       mdl_carry = 1'b0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .CLK(clk), .RST_N(rst_n), .START(start8), .A(a8), .B(b8),
    .BUSY(busy8), .DONE(done8), .SUM(sum8), .CARRY(carry8)
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .CLK(clk), .RST_N(rst_n), .START(start1), .A(a1), .B(b1),
    .BUSY(busy1), .DONE(done1), .SUM(sum1), .CARRY(carry1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after FIN.
  // poke_at > 0 raises START with new operands during cycle poke_at after acceptance.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input int poke_at, input string tag);
    logic [8:0] exp;
    exp    = {1'b0, a} + {1'b0, b};
    a8     = a;
    b8     = b;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8     = 8'($urandom);
    b8     = 8'($urandom);
    check_eq({tag, " busy0"}, busy8, 1'b1);
    check_eq({tag, " done0"}, done8, 1'b0);
    for (int n = 1; n <= 8; n++) begin
      if (n == poke_at) begin
        start8 = 1'b1;
        a8     = 8'h55;
        b8     = 8'h55;
      end else begin
        start8 = 1'b0;
      end
      tick();
      if (n < 8) begin
        check_eq({tag, " busy"}, busy8, 1'b1);
        check_eq({tag, " done"}, done8, 1'b0);
        check_eq({tag, " sum_hold"}, {23'd0, carry8, sum8}, {23'd0, mdl_carry, mdl_sum});
      end else begin
        check_eq({tag, " fin_busy"}, busy8, 1'b0);
        check_eq({tag, " fin_done"}, done8, 1'b1);
        check_eq({tag, " result"}, {23'd0, carry8, sum8}, {23'd0, exp});
      end
    end
    mdl_sum   = exp[7:0];
    mdl_carry = exp[8];
    start8    = 1'b0;
    tick();
    check_eq({tag, " idle_done"}, done8, 1'b0);
    check_eq({tag, " idle_busy"}, busy8, 1'b0);
    check_eq({tag, " idle_sum"}, {23'd0, carry8, sum8}, {23'd0, exp});
  endtask

  task automatic op1(input logic a, input logic b, input logic [1:0] exp, input string tag);
    a1     = a;
    b1     = b;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    a1     = ~a;
    b1     = ~b;
    check_eq({tag, " busy"}, {busy1, done1}, 2'b10);
    tick();
    check_eq({tag, " done"}, {busy1, done1}, 2'b01);
    check_eq({tag, " result"}, {carry1, sum1}, exp);
    tick();
    check_eq({tag, " after"}, {busy1, done1}, 2'b00);
  endtask

  initial begin
    rst_n  = 1'b0;
    start8 = 1'b1;
    start1 = 1'b1;
    a8 = 8'hAA; b8 = 8'hAA; a1 = 1'b1; b1 = 1'b1;
    tick();
    tick();
    check_eq("rst_busy8", busy8, 1'b0);
    check_eq("rst_done8", done8, 1'b0);
    check_eq("rst_sum8", {23'd0, carry8, sum8}, 32'd0);
    check_eq("rst_w1", {busy1, done1, carry1, sum1}, 4'b0000);
    start8 = 1'b0;
    start1 = 1'b0;
    rst_n  = 1'b1;
    tick();
    check_eq("rst_start_ignored", busy8, 1'b0);

    op8(8'h0F, 8'h01, 0, "add_0f_01");
    op8(8'hFF, 8'h01, 0, "add_ff_01");
    op8(8'hFF, 8'hFF, 0, "add_ff_ff");
    op8(8'h0F, 8'h01, 3, "restart_add");
    op8(8'h80, 8'h80, 8, "restart_fin");
    op8(8'h00, 8'h00, 0, "add_zero");

    // Reset in the middle of an addition clears the held result and suppresses DONE.
    a8 = 8'h3C; b8 = 8'h5A; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int n = 1; n <= 3; n++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("midrst_state", {busy8, done8}, 2'b00);
    check_eq("midrst_sum", {23'd0, carry8, sum8}, 32'd0);
    for (int n = 0; n < 8; n++) begin
      check_eq("midrst_nodone", {busy8, done8}, 2'b00);
      tick();
    end
    mdl_sum   = 8'h00;
    mdl_carry = 1'b0;
    op8(8'h3C, 8'h5A, 0, "after_rst");

    op1(1'b0, 1'b0, 2'b00, "w1_00");
    op1(1'b0, 1'b1, 2'b01, "w1_01");
    op1(1'b1, 1'b0, 2'b01, "w1_10");
    op1(1'b1, 1'b1, 2'b10, "w1_11");

    for (int i = 0; i < 1000; i++) begin
      op8(8'($urandom), 8'($urandom), 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_serial_adder_ctrl
